// File: rtl/seq_pkg.sv
// Shared constants for the step-sequencer grid controller.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
// Contents: default grid geometry, Direction one-hot codes, control FSM encoding.
package seq_pkg;

    localparam int DEF_ROWS     = 12;
    localparam int DEF_STEPS    = 16;
    localparam int DEF_PATTERNS = 4;

    // Direction bit assignment: y grows downward, so "up" decrements y.
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } ctrl_state_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/seq_input_sync.sv
// 2-FF synchroniser with previous-value register, rising-edge and change pulses.
// Latency: async_in reaches sync_out after 2 core clock edges; pulses are combinational from sync/prev.
// Backpressure: none; pulses last exactly one cycle and are lost if the consumer ignores them.
// Ports: async_in (W) raw level; sync_out/prev_out synced value and its one-cycle-old copy;
//        rise per-bit rising edge; change = synced value differs from previous.
module seq_input_sync #(
    parameter int W = 1
) (
    input  logic         CLOCK_50,
    input  logic         nReset,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] sync_out,
    output logic [W-1:0] prev_out,
    output logic [W-1:0] rise,
    output logic         change
);

    logic [W-1:0] meta;

    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            meta     <= '0;
            sync_out <= '0;
            prev_out <= '0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
            prev_out <= sync_out;
        end
    end

    assign rise   = sync_out & ~prev_out;
    assign change = |(sync_out ^ prev_out);

endmodule

// File: rtl/seq_grid_controller.sv
// Step-sequencer grid: cursor editing of PATTERNS x STEPS x ROWS cells, draw requests, bar-aligned playback.
// Latency: input to effect is 3 edges (2 sync + 1 register); draw_valid rises the cycle after the event.
// Backpressure: draw_valid/draw_ready handshake; edit events arriving while a request is pending are dropped.
// Ports: Direction/Command/bpm_step async levels; pat_sel edit+requested play pattern; play_en;
//        select_note/play_step playback outputs; draw_* cursor redraw request.
// Option: define SEQ_CURSOR_WRAP_EN to wrap the cursor at grid edges (default: saturate, no request).
module seq_grid_controller
    import seq_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int STEPS    = DEF_STEPS,
    parameter int PATTERNS = DEF_PATTERNS
) (
    input  logic                        CLOCK_50,
    input  logic                        nReset,
    input  logic [3:0]                  Direction,
    input  logic                        Command,
    input  logic [$clog2(PATTERNS)-1:0] pat_sel,
    input  logic                        play_en,
    input  logic                        bpm_step,
    output logic [ROWS-1:0]             select_note,
    output logic [$clog2(STEPS)-1:0]    play_step,
    output logic                        draw_valid,
    input  logic                        draw_ready,
    output logic [$clog2(STEPS)-1:0]    draw_x,
    output logic [$clog2(ROWS)-1:0]     draw_y,
    output logic [$clog2(STEPS)-1:0]    draw_old_x,
    output logic [$clog2(ROWS)-1:0]     draw_old_y,
    output logic                        draw_state
);

    localparam int XW = $clog2(STEPS);
    localparam int YW = $clog2(ROWS);
    localparam int PW = $clog2(PATTERNS);

    // ---------------- input synchronisers ----------------
    logic [3:0] dir_q, dir_prev, dir_rise;
    logic       dir_chg;
    logic       cmd_q, cmd_prev, cmd_rise, cmd_chg;
    logic       bpm_q, bpm_prev, bpm_rise, bpm_chg;

    seq_input_sync #(.W(4)) u_dir_sync (
        .CLOCK_50 (CLOCK_50), .nReset (nReset), .async_in (Direction),
        .sync_out (dir_q), .prev_out (dir_prev), .rise (dir_rise), .change (dir_chg)
    );

    seq_input_sync #(.W(1)) u_cmd_sync (
        .CLOCK_50 (CLOCK_50), .nReset (nReset), .async_in (Command),
        .sync_out (cmd_q), .prev_out (cmd_prev), .rise (cmd_rise), .change (cmd_chg)
    );

    seq_input_sync #(.W(1)) u_bpm_sync (
        .CLOCK_50 (CLOCK_50), .nReset (nReset), .async_in (bpm_step),
        .sync_out (bpm_q), .prev_out (bpm_prev), .rise (bpm_rise), .change (bpm_chg)
    );

    logic unused_sync;
    assign unused_sync = ^{dir_rise, cmd_q, cmd_prev, cmd_chg, bpm_q, bpm_prev, bpm_chg};

    // Non-one-hot Direction values (released, or two keys held) never generate a move.
    logic dir_evt, cmd_evt, tick;
    assign dir_evt = is_onehot4(dir_q) && dir_chg;
    assign cmd_evt = cmd_rise;
    assign tick    = bpm_rise;

    // ---------------- state ----------------
    ctrl_state_t    state_q, state_d;
    logic [XW-1:0]  cur_x, nx;
    logic [YW-1:0]  cur_y, ny;
    logic [PW-1:0]  last_pat;   // pattern shown by the most recent draw request
    logic [PW-1:0]  play_pat;
    logic [XW-1:0]  play_ptr;
    logic [ROWS-1:0] cells [PATTERNS][STEPS];

    // ---------------- cursor move ----------------
    always_comb begin
        nx = cur_x;
        ny = cur_y;
        case (dir_q)
            DIR_UP: begin
                if (cur_y != '0) ny = cur_y - 1'b1;
`ifdef SEQ_CURSOR_WRAP_EN
                else ny = YW'(ROWS - 1);
`endif
            end
            DIR_DOWN: begin
                if (cur_y != YW'(ROWS - 1)) ny = cur_y + 1'b1;
`ifdef SEQ_CURSOR_WRAP_EN
                else ny = '0;
`endif
            end
            DIR_LEFT: begin
                if (cur_x != '0) nx = cur_x - 1'b1;
`ifdef SEQ_CURSOR_WRAP_EN
                else nx = XW'(STEPS - 1);
`endif
            end
            DIR_RIGHT: begin
                if (cur_x != XW'(STEPS - 1)) nx = cur_x + 1'b1;
`ifdef SEQ_CURSOR_WRAP_EN
                else nx = '0;
`endif
            end
            default: ;
        endcase
    end

    logic idle, move_chg, do_move, do_cmd, do_pat;
    logic cur_cell, next_cell;

    assign idle      = (state_q == S_IDLE);
    assign move_chg  = (nx != cur_x) || (ny != cur_y);
    assign cur_cell  = cells[pat_sel][cur_x][cur_y];
    assign next_cell = cells[pat_sel][nx][ny];

    // Priority: a dir event (even a saturated no-op) drops a same-cycle cmd.
    // A pattern switch waits until no edit is pending, and is remembered across REQ.
    assign do_move = idle && dir_evt && move_chg;
    assign do_cmd  = idle && cmd_evt && !dir_evt;
    assign do_pat  = idle && !dir_evt && !cmd_evt && (pat_sel != last_pat);

    // ---------------- control FSM ----------------
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (do_move || do_cmd || do_pat) state_d = S_REQ;
            S_REQ:  if (draw_ready)                  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        draw_valid = (state_q == S_REQ);
    end

    // ---------------- cursor / draw registers ----------------
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            cur_x      <= '0;
            cur_y      <= '0;
            draw_old_x <= '0;
            draw_old_y <= '0;
            draw_state <= 1'b0;
            last_pat   <= '0;
        end else if (do_move) begin
            draw_old_x <= cur_x;
            draw_old_y <= cur_y;
            cur_x      <= nx;
            cur_y      <= ny;
            draw_state <= next_cell;
            last_pat   <= pat_sel;
        end else if (do_cmd || do_pat) begin
            // Redraw of the cell in place: old and new coordinates coincide.
            draw_old_x <= cur_x;
            draw_old_y <= cur_y;
            draw_state <= do_cmd ? ~cur_cell : cur_cell;
            last_pat   <= pat_sel;
        end
    end

    assign draw_x = cur_x;
    assign draw_y = cur_y;

    // ---------------- cell storage ----------------
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            for (int p = 0; p < PATTERNS; p++)
                for (int s = 0; s < STEPS; s++)
                    cells[p][s] <= '0;
        end else if (do_cmd) begin
            cells[pat_sel][cur_x][cur_y] <= ~cur_cell;
        end
    end

    // ---------------- playback ----------------
    // Reads use the pre-edge cell contents, so a same-cycle toggle is heard on the next pass.
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            play_ptr    <= '0;
            play_step   <= '0;
            select_note <= '0;
            play_pat    <= '0;
        end else if (!play_en) begin
            play_ptr    <= '0;
            play_step   <= '0;
            select_note <= '0;
            play_pat    <= pat_sel;
        end else if (tick) begin
            select_note <= cells[play_pat][play_ptr];
            play_step   <= play_ptr;
            if (play_ptr == XW'(STEPS - 1)) begin
                play_ptr <= '0;
                play_pat <= pat_sel;   // pattern changes take effect at the bar line
            end else begin
                play_ptr <= play_ptr + 1'b1;
            end
        end
    end

endmodule
